// File: rtl/alu_pkg.sv
// Shared ALU types and widths for the arbiter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;
    localparam int OP_W   = 5;
    localparam int DATA_W = 8;

    typedef enum logic [OP_W-1:0] {
        ALU_NOP    = 5'b00000,
        ALU_PASS_B = 5'b00001,
        ALU_INC    = 5'b00100
    } alu_op_e;

    // Op is kept as raw bits so undefined codes pass through untouched.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus: packed request lanes and per-requester response slots.
// Latency: none (wiring only).
// Backpressure: req_ready per lane, resp_ready per lane.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [NUM_REQ*DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first eligible lane after last_grant wins.
// Latency: combinational.
// Backpressure: lanes not eligible are skipped; grant is one-hot or zero.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant
);
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && elig[(int'(last_grant) + k) % N]) begin
                grant[(int'(last_grant) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters, round-robin.
// Latency: 1 cycle from request accept to resp_valid.
// Backpressure: a lane with a full, non-draining response slot is not granted.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      bus,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src_a,
    output logic [DATA_W-1:0] alu_src_b,
    input  logic [DATA_W-1:0] alu_result
);
    logic [NUM_REQ-1:0]             elig;
    logic [NUM_REQ-1:0]             grant_raw;
    logic [NUM_REQ-1:0]             grant;
    req_t                           sel;

    logic [NUM_REQ-1:0]             resp_valid_q, resp_valid_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] resp_data_q,  resp_data_d;
    logic [IDX_W-1:0]               last_grant_q, last_grant_d;

    assign elig = bus.req_valid & (~resp_valid_q | bus.resp_ready);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .elig       (elig),
        .last_grant (last_grant_q),
        .grant      (grant_raw)
    );

    // Nothing is accepted while reset is held, so the ALU sees NOP.
    assign grant = rst ? '0 : grant_raw;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.op = bus.req_op[i*OP_W +: OP_W];
                sel.a  = bus.req_a[i*DATA_W +: DATA_W];
                sel.b  = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign alu_op    = sel.op;
    assign alu_src_a = sel.a;
    assign alu_src_b = sel.b;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        last_grant_d = last_grant_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                resp_valid_d[i] = 1'b1;
                resp_data_d[i]  = alu_result;
                last_grant_d    = IDX_W'(i);
            end else if (resp_valid_q[i] && bus.resp_ready[i]) begin
                resp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed plan items then random traffic.
// Latency: expected responses are queued per requester and checked on drain.
// Backpressure: resp_ready is randomized to exercise full and draining slots.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    typedef struct {
        logic              rst;
        logic [N-1:0]      rdy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [N-1:0]      rv;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_src_a;
    logic [DATA_W-1:0] alu_src_b;
    logic [DATA_W-1:0] alu_result;

    alu_arbiter_if #(.NUM_REQ(N)) bus ();

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        if (op == ALU_INC)    return a + 8'd1;
        if (op == ALU_PASS_B) return b;
        return 8'h00;
    endfunction

    always_comb alu_result = alu_ref(alu_op, alu_src_a, alu_src_b);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus for the next cycle and the reference model state.
    logic              rst_in;
    logic [N-1:0]      v_in, rr_in;
    logic [OP_W-1:0]   op_in [N];
    logic [DATA_W-1:0] a_in  [N];
    logic [DATA_W-1:0] b_in  [N];

    int                m_last;
    bit                m_full [N];
    logic [DATA_W-1:0] exp_data [N][$];
    exp_t              exp_q [$];

    task automatic set_req(input int i, input logic [OP_W-1:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        op_in[i] = op;
        a_in[i]  = a;
        b_in[i]  = b;
    endtask

    task automatic cycle();
        exp_t e;
        int   w;
        int   c;
        @(posedge clk);
        #1;
        rst            = rst_in;
        bus.req_valid  = v_in;
        bus.resp_ready = rr_in;
        for (int i = 0; i < N; i++) begin
            bus.req_op[i*OP_W +: OP_W]   = op_in[i];
            bus.req_a[i*DATA_W +: DATA_W] = a_in[i];
            bus.req_b[i*DATA_W +: DATA_W] = b_in[i];
        end
        // Winner: first requester after the last one served that wants service and has room.
        w = -1;
        if (!rst_in) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (w < 0 && v_in[c] && (!m_full[c] || rr_in[c])) w = c;
            end
        end
        e.rst = rst_in;
        e.rdy = '0;
        e.op  = '0;
        e.a   = '0;
        e.b   = '0;
        for (int i = 0; i < N; i++) e.rv[i] = m_full[i];
        if (w >= 0) begin
            e.rdy[w] = 1'b1;
            e.op     = op_in[w];
            e.a      = a_in[w];
            e.b      = b_in[w];
        end
        exp_q.push_back(e);
        if (rst_in) begin
            for (int i = 0; i < N; i++) begin
                m_full[i] = 1'b0;
                exp_data[i].delete();
            end
            m_last = N - 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i == w) begin
                    m_full[i] = 1'b1;
                    exp_data[i].push_back(alu_ref(op_in[i], a_in[i], b_in[i]));
                end else if (m_full[i] && rr_in[i]) begin
                    m_full[i] = 1'b0;
                end
            end
            if (w >= 0) m_last = w;
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("req_ready",  32'(bus.req_ready),  32'(mon_e.rdy));
            chk("alu_op",     32'(alu_op),         32'(mon_e.op));
            chk("alu_src_a",  32'(alu_src_a),      32'(mon_e.a));
            chk("alu_src_b",  32'(alu_src_b),      32'(mon_e.b));
            chk("resp_valid", 32'(bus.resp_valid), 32'(mon_e.rv));
            if (!mon_e.rst) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.resp_valid[i] && bus.resp_ready[i]) begin
                        if (exp_data[i].size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL resp_unexpected: lane %0d drained with no expected result", i);
                        end else begin
                            chk("resp_data", 32'(bus.resp_data[i*DATA_W +: DATA_W]),
                                32'(exp_data[i].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.resp_ready = '0;
        bus.req_op     = '1;
        bus.req_a      = '1;
        bus.req_b      = '1;
        rst_in = 1'b0;
        v_in   = '0;
        rr_in  = '0;
        for (int i = 0; i < N; i++) begin
            set_req(i, ALU_NOP, 8'h00, 8'h00);
            m_full[i] = 1'b0;
        end
        m_last = N - 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_data",  32'(bus.resp_data),  32'h0);
        chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
        chk("rst_alu_op",     32'(alu_op),         32'h0);

        // Single request, one-cycle latency.
        v_in = 2'b01;
        set_req(0, ALU_INC, 8'h41, 8'h00);
        cycle();
        #1 chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
        v_in = 2'b00;
        cycle();
        #1;
        chk("t1_resp_valid0", 32'(bus.resp_valid[0]), 32'h1);
        chk("t1_resp_data0",  32'(bus.resp_data[7:0]), 32'h42);
        chk("t1_idle_op",     32'(alu_op), 32'h0);
        rr_in = 2'b01;
        cycle();

        // Wrap-around, pass-through and undefined op.
        v_in  = 2'b10;
        rr_in = 2'b10;
        set_req(1, ALU_INC, 8'hFF, 8'h00);
        cycle();
        set_req(1, ALU_PASS_B, 8'h00, 8'h5A);
        cycle();
        #1 chk("wrap_ff", 32'(bus.resp_data[15:8]), 32'h00);
        set_req(1, 5'b11111, 8'h33, 8'h44);
        cycle();
        #1 chk("pass_b", 32'(bus.resp_data[15:8]), 32'h5A);
        v_in = 2'b00;
        cycle();
        #1 chk("undef_op", 32'(bus.resp_data[15:8]), 32'h00);
        cycle();

        // Contention straight out of reset.
        rst_in = 1'b1;
        v_in   = 2'b11;
        rr_in  = 2'b11;
        cycle();
        rst_in = 1'b0;
        set_req(0, ALU_INC, 8'h10, 8'h00);
        set_req(1, ALU_INC, 8'h20, 8'h00);
        cycle();
        #1 chk("first_grant", 32'(bus.req_ready), 32'h1);
        repeat (3) cycle();

        // Backpressure on requester 0, then drain and refill together.
        rr_in = 2'b10;
        set_req(0, ALU_PASS_B, 8'h00, 8'hC3);
        repeat (4) cycle();
        rr_in = 2'b11;
        cycle();
        #1 chk("drain_refill", 32'(bus.req_ready), 32'h1);

        // Reset the cycle after a grant.
        v_in = 2'b01;
        set_req(0, ALU_INC, 8'h7F, 8'h00);
        cycle();
        rst_in = 1'b1;
        v_in   = 2'b00;
        cycle();
        rst_in = 1'b0;
        cycle();
        #1;
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("mid_rst_data",  32'(bus.resp_data),  32'h0);
        v_in = 2'b11;
        cycle();
        #1 chk("post_rst_grant", 32'(bus.req_ready), 32'h1);

        // Idle with a full slot left undrained.
        v_in  = 2'b00;
        rr_in = 2'b00;
        repeat (5) cycle();

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            rst_in = ($urandom_range(0, 59) == 0);
            v_in   = N'($urandom);
            rr_in  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       op_in[i] = ALU_NOP;
                    1:       op_in[i] = ALU_PASS_B;
                    2:       op_in[i] = ALU_INC;
                    default: op_in[i] = OP_W'($urandom);
                endcase
                a_in[i] = DATA_W'($urandom);
                b_in[i] = DATA_W'($urandom);
            end
            cycle();
        end

        rst_in = 1'b0;
        v_in   = 2'b00;
        rr_in  = 2'b11;
        repeat (3) cycle();
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU between NUM_REQ independent requesters, such as the execute stage and a loop/address unit.
- Each cycle it grants one request using a round-robin policy and drives the ALU operand and op ports.
- It captures the ALU result into a per-requester response register with valid/ready handshakes on both sides.
- It drives NOP (all-zero op and operands) to the ALU whenever no request is granted.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- OP_W, 5, ALU op code width.
- DATA_W, 8, operand and result width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
- req_op  in  NUM_REQ*OP_W  packed op codes; requester i occupies slice [i*OP_W +: OP_W].
- req_a  in  NUM_REQ*DATA_W  packed srcA operands.
- req_b  in  NUM_REQ*DATA_W  packed srcB operands.
- resp_valid  out  NUM_REQ  per-requester result valid.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  NUM_REQ*DATA_W  packed results.
- alu_op  out  OP_W  drives the ALU aluOp input.
- alu_src_a  out  DATA_W  drives the ALU srcA input.
- alu_src_b  out  DATA_W  drives the ALU srcB input.
- alu_result  in  DATA_W  ALU result; combinational from alu_op, alu_src_a and alu_src_b.

Behaviour:
- Reset (rst=1 at a rising edge):
  - resp_valid = 0 and resp_data = 0 for all requesters.
  - last_grant = NUM_REQ-1, so requester 0 has highest priority on the first cycle after reset.
  - Reset mid-operation discards any captured result and drops resp_valid; there is no completion.
  - While rst is high, req_ready = 0 and the ALU ports carry NOP.
- Eligibility:
  - elig[i] = req_valid[i] & (~resp_valid[i] | resp_ready[i]).
  - A requester whose response slot is full and not draining this cycle is not eligible.
  - The slot draining and refilling in the same cycle is legal.
- Arbitration (combinational, rotating priority):
  - Search order is last_grant+1, last_grant+2, ..., wrapping modulo NUM_REQ.
  - The first eligible requester wins; grant is one-hot or zero.
  - req_ready = grant.
- ALU drive:
  - With a grant: alu_op, alu_src_a and alu_src_b carry the winner's slices.
  - With no grant: all three are 0, i.e. op 5'b00000 = NOP.
  - Op codes pass through unmodified; undefined codes are forwarded and their ALU result (0) is returned normally.
- Capture at the rising edge when grant[w]=1:
  - resp_data[w] <= alu_result; resp_valid[w] <= 1; last_grant <= w.
  - Latency is exactly 1 cycle: request accepted in cycle N gives resp_valid in cycle N+1.
- Drain:
  - When resp_valid[i] & resp_ready[i] and requester i is not granted in the same cycle, resp_valid[i] <= 0.
  - resp_data[i] holds its last value after draining.
- Hold and stability:
  - resp_data[i] and resp_valid[i] are stable while resp_valid[i]=1 and resp_ready[i]=0.
  - last_grant is unchanged in cycles with no grant.
- Throughput:
  - One request per cycle in total.
  - A single requester with resp_ready held high is granted every cycle.
- Fairness: under continuous contention, grants rotate 0,1,...,NUM_REQ-1; starvation-free.
- Width rule: results are DATA_W bits with no carry out; the ALU's wrap-around (0xFF+1 = 0x00) is returned as-is.

Decomposition:
- Shared package alu_pkg holds:
  - OP_W and DATA_W constants.
  - alu_op_e enum: ALU_NOP=5'b00000, ALU_PASS_B=5'b00001, ALU_INC=5'b00100.
  - The request struct {op, a, b}.
- One sub-module, rr_arbiter, implements the NUM_REQ-wide rotating-priority pick.
  - Inputs: elig and last_grant.
  - Output: one-hot grant.
  - It is reusable by later shared-resource controllers.
- The top level handles the ALU mux, response registers and last_grant update.

Test Plan:
- Reset then single request: req 0 with op=ALU_INC, a=0x41 in cycle 1.
  - req_ready[0]=1 in cycle 1.
  - resp_valid[0]=1, resp_data[0]=0x42 in cycle 2.
  - alu_op=0 in cycle 2 (no request).
- Wrap: req 1 with op=ALU_INC, a=0xFF → resp_data[1]=0x00; PASS_B with b=0x5A → 0x5A; op=5'b11111 → 0x00.
- Contention: both requesters valid every cycle with resp_ready=1 → grant sequence 0,1,0,1.
  - Each result appears 1 cycle after its grant.
  - The first grant after reset is requester 0.
- Backpressure: resp_ready[0]=0 with its slot full and req 0 still valid.
  - req_ready[0]=0 and resp_data[0] held.
  - Requester 1 is served every cycle.
  - Raising resp_ready[0] grants req 0 in the same cycle as the drain.
- Reset mid-operation: assert rst in the cycle after a grant.
  - resp_valid=0 and resp_data=0 next cycle.
  - After reset, requester 0 again has priority.
- Idle: no req_valid for 5 cycles → alu_op, alu_src_a and alu_src_b are all 0, and resp_valid is unchanged.
